// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - UART command decoder with byte FIFO; optional echo path enabled by CMD_ECHO_EN
module uart_cmd_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_done,
    input  logic             tx_busy,
    output logic             run_en,
    output logic             mode_down,
    output logic             clear_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic             overflow,
    output logic             tx_start,
    output logic [7:0]       tx_data
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]   PTR_ONE = 1;
    localparam logic [ERR_W-1:0] ERR_ONE = 1;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
`ifdef CMD_ECHO_EN
        ECHO,
        TXWAIT,
`endif
        EXEC
    } state_t;

    state_t         state;
    logic [7:0]     mem [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic [7:0]     rd_data;
    logic [7:0]     cmd_reg;
    logic           fifo_empty;
    logic           fifo_full;
    logic           push;
    logic           pop;

    // Full is judged on registered pointers, so a same-cycle pop never rescues a push
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign push       = rx_done && !fifo_full;
    assign pop        = (state == FETCH) && !fifo_empty;
    assign rd_data    = mem[rd_ptr[PTR_W-1:0]];

    // FIFO pointers and the sticky overflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (rx_done && fifo_full) begin
                overflow <= 1'b1;
            end
        end
    end

    // FIFO storage; contents are don't-care while empty so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= rx_data;
        end
    end

    // Command FSM: fetch one byte, decode it, optionally echo it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cmd_reg     <= 8'h00;
            run_en      <= 1'b0;
            mode_down   <= 1'b0;
            clear_pulse <= 1'b0;
            err_cnt     <= '0;
        end else begin
            clear_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    cmd_reg <= rd_data;
                    state   <= EXEC;
                end
                EXEC: begin
                    case (cmd_reg)
                        8'h72, 8'h52: run_en      <= !run_en;
                        8'h6D, 8'h4D: mode_down   <= !mode_down;
                        8'h63, 8'h43: clear_pulse <= 1'b1;
                        8'h0D, 8'h0A: ;
                        default: begin
                            if (err_cnt != ERR_MAX) begin
                                err_cnt <= err_cnt + ERR_ONE;
                            end
                        end
                    endcase
`ifdef CMD_ECHO_EN
                    state <= ECHO;
`else
                    state <= IDLE;
`endif
                end
`ifdef CMD_ECHO_EN
                ECHO: begin
                    if (!tx_busy) begin
                        state <= TXWAIT;
                    end
                end
                TXWAIT: begin
                    if (tx_busy) begin
                        state <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CMD_ECHO_EN
    // Echo request fires in the same cycle the transmitter is seen idle
    assign tx_start = (state == ECHO) && !tx_busy;
    assign tx_data  = cmd_reg;
`else
    logic unused_tx_busy;
    assign unused_tx_busy = tx_busy;
    assign tx_start       = 1'b0;
    assign tx_data        = 8'h00;
`endif

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - scoreboard bench for uart_cmd_ctrl
module tb_uart_cmd_ctrl;
    localparam int ERR_W = 8;
`ifdef CMD_ECHO_EN
    localparam int GAP   = 12;
    localparam int DRAIN = 120;
`else
    localparam int GAP   = 3;
    localparam int DRAIN = 30;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       rx_data;
    logic             rx_done;
    logic             tx_busy;
    logic             run_en;
    logic             mode_down;
    logic             clear_pulse;
    logic [ERR_W-1:0] err_cnt;
    logic             overflow;
    logic             tx_start;
    logic [7:0]       tx_data;

    int checks   = 0;
    int failures = 0;
    int tx_pulses = 0;
    int c0;

    logic [10:0] exp_q[$];
    logic [7:0]  echo_q[$];
    logic        m_run  = 1'b0;
    logic        m_mode = 1'b0;
    logic [7:0]  m_err  = 8'h00;
    logic        p_run  = 1'b0;
    logic        p_mode = 1'b0;
    logic [7:0]  p_err  = 8'h00;
`ifdef CMD_ECHO_EN
    logic        hold_busy = 1'b0;
`endif

    uart_cmd_ctrl #(.FIFO_DEPTH(4), .ERR_W(ERR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .tx_busy     (tx_busy),
        .run_en      (run_en),
        .mode_down   (mode_down),
        .clear_pulse (clear_pulse),
        .err_cnt     (err_cnt),
        .overflow    (overflow),
        .tx_start    (tx_start),
        .tx_data     (tx_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [7:0] b);
        case (b)
            8'h72, 8'h52: begin
                m_run = !m_run;
                exp_q.push_back({m_run, m_mode, 1'b0, m_err});
            end
            8'h6D, 8'h4D: begin
                m_mode = !m_mode;
                exp_q.push_back({m_run, m_mode, 1'b0, m_err});
            end
            8'h63, 8'h43: exp_q.push_back({m_run, m_mode, 1'b1, m_err});
            8'h0D, 8'h0A: ;
            default: begin
                if (m_err != 8'hFF) begin
                    m_err = m_err + 8'h01;
                    exp_q.push_back({m_run, m_mode, 1'b0, m_err});
                end
            end
        endcase
`ifdef CMD_ECHO_EN
        echo_q.push_back(b);
`endif
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic executes);
        rx_data = b;
        rx_done = 1'b1;
        if (executes) model(b);
        @(posedge clk);
        #1;
        rx_done = 1'b0;
    endtask

    // Output monitor: every visible update pops one expected record
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                p_run  = 1'b0;
                p_mode = 1'b0;
                p_err  = 8'h00;
            end else begin
                if (clear_pulse || run_en !== p_run || mode_down !== p_mode || err_cnt !== p_err) begin
                    if (exp_q.size() == 0)
                        check("unexpected_update", {run_en, mode_down, clear_pulse, err_cnt},
                              {p_run, p_mode, 1'b0, p_err});
                    else
                        check("cmd_result", {run_en, mode_down, clear_pulse, err_cnt}, exp_q.pop_front());
                end
                p_run  = run_en;
                p_mode = mode_down;
                p_err  = err_cnt;
                if (tx_start) begin
                    tx_pulses++;
                    if (echo_q.size() == 0)
                        check("unexpected_tx_start", tx_start, 1'b0);
                    else
                        check("echo_data", tx_data, echo_q.pop_front());
                end
            end
        end
    end

`ifdef CMD_ECHO_EN
    // Transmitter model: busy for three cycles after each start, or while held
    initial begin
        logic pulse;
        int   busy_cnt;
        busy_cnt = 0;
        tx_busy  = 1'b0;
        forever begin
            @(negedge clk);
            pulse = tx_start;
            @(posedge clk);
            #1;
            if (pulse) busy_cnt = 3;
            else if (busy_cnt > 0) busy_cnt--;
            tx_busy = hold_busy || (busy_cnt > 0);
        end
    end
`endif

    initial begin
        rst     = 1'b0;
        rx_done = 1'b0;
        rx_data = 8'h00;
`ifndef CMD_ECHO_EN
        tx_busy = 1'b0;
`endif
        idle(2);
        check("rst_run_en", run_en, 1'b0);
        check("rst_mode_down", mode_down, 1'b0);
        check("rst_clear_pulse", clear_pulse, 1'b0);
        check("rst_err_cnt", err_cnt, 8'h00);
        check("rst_overflow", overflow, 1'b0);
        check("rst_tx_start", tx_start, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        rst = 1'b1;
        idle(1);

        send(8'h72, 1'b1);
        idle(2);
        check("run_before_n4", run_en, 1'b0);
        idle(1);
        check("run_at_n4", run_en, 1'b1);
        idle(DRAIN);
        send(8'h52, 1'b1);
        idle(DRAIN);
        check("run_after_R", run_en, 1'b0);

        send(8'h6D, 1'b1);
        idle(GAP);
        send(8'h63, 1'b1);
        idle(DRAIN);
        check("mode_after_m", mode_down, 1'b1);
        check("run_after_mc", run_en, 1'b0);
        send(8'h43, 1'b1);
        idle(DRAIN);
        check("mode_after_c", mode_down, 1'b1);

        send(8'h41, 1'b1);
        idle(GAP);
        send(8'h0D, 1'b1);
        idle(GAP);
        send(8'h7A, 1'b1);
        idle(DRAIN);
        check("err_cnt_two", err_cnt, 8'd2);

        for (int i = 0; i < 300; i++) begin
            send(8'h30 + 8'(i % 10), 1'b1);
            idle(GAP);
        end
        idle(DRAIN);
        check("err_cnt_sat", err_cnt, 8'hFF);

        send(8'h72, 1'b1);
        send(8'h6D, 1'b1);
        send(8'h63, 1'b1);
        send(8'h72, 1'b1);
        send(8'h6D, 1'b1);
        idle(DRAIN);
        check("burst5_no_overflow", overflow, 1'b0);
        check("burst5_sb_empty", exp_q.size(), 0);

`ifdef CMD_ECHO_EN
        hold_busy = 1'b1;
        c0 = tx_pulses;
        send(8'h72, 1'b1);
        idle(8);
        check("echo_withheld", tx_pulses, c0);
        send(8'h6D, 1'b1);
        send(8'h63, 1'b1);
        send(8'h72, 1'b1);
        send(8'h6D, 1'b1);
        send(8'h63, 1'b0);
        send(8'h72, 1'b0);
        idle(2);
        check("overflow_set", overflow, 1'b1);
        hold_busy = 1'b0;
        idle(DRAIN);
        check("echo_count", tx_pulses, c0 + 5);
        check("echo_sb_empty", echo_q.size(), 0);
`else
        send(8'h72, 1'b1);
        send(8'h6D, 1'b1);
        send(8'h72, 1'b1);
        send(8'h6D, 1'b1);
        send(8'h72, 1'b1);
        send(8'h63, 1'b0);
        idle(DRAIN);
        check("overflow_set", overflow, 1'b1);
`endif
        check("burst_sb_empty", exp_q.size(), 0);

        send(8'h72, 1'b0);
        send(8'h72, 1'b0);
        send(8'h72, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("arst_run_en", run_en, 1'b0);
        check("arst_mode_down", mode_down, 1'b0);
        check("arst_clear_pulse", clear_pulse, 1'b0);
        check("arst_err_cnt", err_cnt, 8'h00);
        check("arst_overflow", overflow, 1'b0);
        check("arst_tx_start", tx_start, 1'b0);
        check("arst_tx_data", tx_data, 8'h00);
        m_run  = 1'b0;
        m_mode = 1'b0;
        m_err  = 8'h00;
        exp_q.delete();
        echo_q.delete();
        idle(2);
        rst = 1'b1;
        idle(DRAIN);
        check("post_rst_run_en", run_en, 1'b0);
        check("post_rst_err_cnt", err_cnt, 8'h00);
        check("final_sb_empty", exp_q.size(), 0);
        check("final_echo_empty", echo_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
